dnn_cmd_decoder: RTL and testbench

Receiver on the accelerator side of the CPU→DNN instruction path. Accepts custom DNN instructions forwarded by the CPU control unit, identified by instruction bits [1:0] = 01 (DNN core 1) or 10 (DNN core 2). It buffers them in a small FIFO, decodes them into command fields, and issues them to the DNN engine over a valid/ready handshake. RUN commands are serialized by waiting for engine completion.

---
 rtl/dnn_pkg.sv | 37 +++
 rtl/dnn_cmd_fifo.sv | 49 ++++
 rtl/dnn_cmd_decoder.sv | 149 ++++++++++++++
 tb/tb_dnn_cmd_decoder.sv | 500 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dnn_pkg.sv
// Shared types for the CPU->DNN command decoder: opcodes, decoded command
// record, target encodings and decoder FSM states.
package dnn_pkg;

   typedef enum logic [1:0] {
      LDW = 2'd0,
      LDI = 2'd1,
      RUN = 2'd2,
      ST  = 2'd3
   } dnn_op_e;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_ISSUE     = 2'd1,
      S_WAIT_DONE = 2'd2
   } dnn_state_e;

   localparam logic [1:0] DNN_TGT_CORE1 = 2'b01;
   localparam logic [1:0] DNN_TGT_CORE2 = 2'b10;

   localparam int DNN_INST_W = 32;
   localparam int DNN_ADDR_W = 16;
   localparam int DNN_LEN_W  = 9;

   typedef struct packed {
      logic [1:0]            target;
      dnn_op_e               op;
      logic [DNN_ADDR_W-1:0] addr;
      logic [DNN_LEN_W-1:0]  len;
   } dnn_cmd_t;

   // Only the two DNN core encodings are routed to the accelerator.
   function automatic logic dnn_is_dnn_inst(input logic [1:0] tgt);
      return (tgt == DNN_TGT_CORE1) || (tgt == DNN_TGT_CORE2);
   endfunction

endpackage

// File: rtl/dnn_cmd_fifo.sv
// Synchronous instruction FIFO with wrap-bit pointers and async active-low reset.
// Push is expected to be gated by full outside this block.
module dnn_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q;
   logic [AW:0]      rd_ptr_q;

   // Storage is not reset: entries are only ever read behind a valid write.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
      end
   end

   assign rdata = mem_q[rd_ptr_q[AW-1:0]];
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/dnn_cmd_decoder.sv
// Accelerator-side receiver: buffers DNN instructions, decodes and issues them,
// serializing RUN on dnn_done. Optional perf counters under DNN_DEC_PERF_EN.
module dnn_cmd_decoder
   import dnn_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_W     = 16,
   parameter int LEN_W      = 9
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       instruction_to_dnn,
   input  logic              inst_valid,
   output logic              dnn_stall,
   output logic              cmd_valid,
   input  logic              cmd_ready,
   output logic [1:0]        cmd_target,
   output logic [1:0]        cmd_op,
   output logic [ADDR_W-1:0] cmd_addr,
   output logic [LEN_W-1:0]  cmd_len,
   input  logic              dnn_done,
   output logic              busy,
   output logic              err,
   input  logic              err_clr,
   output logic [31:0]       perf_cmd_cnt,
   output logic [31:0]       perf_busy_cnt
);

   logic                  fifo_push;
   logic                  fifo_pop;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [DNN_INST_W-1:0] head_word;
   logic                  head_illegal;
   dnn_cmd_t              head_cmd;

   dnn_state_e            state_q;
   dnn_cmd_t              cmd_q;
   logic                  cmd_valid_q;
   logic                  err_q;
   logic                  busy_w;

   assign fifo_push = inst_valid && dnn_is_dnn_inst(instruction_to_dnn[1:0]) && !fifo_full;
   assign fifo_pop  = (state_q == S_IDLE) && !fifo_empty;

   dnn_cmd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DNN_INST_W)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_push),
      .wdata (instruction_to_dnn),
      .pop   (fifo_pop),
      .rdata (head_word),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // The op field is 5 bits wide on the wire; only 0..3 are defined.
   assign head_illegal = (head_word[6:2] > 5'd3);

   always_comb begin
      head_cmd.target = head_word[1:0];
      head_cmd.op     = dnn_op_e'(head_word[3:2]);
      head_cmd.addr   = head_word[31:16];
      head_cmd.len    = head_word[15:7];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cmd_q       <= '0;
         cmd_valid_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         if (err_clr) begin
            err_q <= 1'b0;
         end
         case (state_q)
            S_IDLE: begin
               if (fifo_pop) begin
                  if (head_illegal) begin
                     err_q <= 1'b1;
                  end else begin
                     cmd_q       <= head_cmd;
                     cmd_valid_q <= 1'b1;
                     state_q     <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               if (cmd_ready) begin
                  cmd_valid_q <= 1'b0;
                  state_q     <= (cmd_q.op == RUN) ? S_WAIT_DONE : S_IDLE;
               end
            end
            S_WAIT_DONE: begin
               if (dnn_done) begin
                  state_q <= S_IDLE;
               end
            end
            default: begin
               state_q     <= S_IDLE;
               cmd_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign busy_w     = (state_q != S_IDLE) || !fifo_empty;
   assign busy       = busy_w;
   assign err        = err_q;
   assign dnn_stall  = fifo_full;
   assign cmd_valid  = cmd_valid_q;
   assign cmd_target = cmd_q.target;
   assign cmd_op     = cmd_q.op;
   assign cmd_addr   = ADDR_W'(cmd_q.addr);
   assign cmd_len    = LEN_W'(cmd_q.len);

`ifdef DNN_DEC_PERF_EN
   logic [31:0] perf_cmd_q;
   logic [31:0] perf_cmd_d;
   logic [31:0] perf_busy_q;
   logic [31:0] perf_busy_d;

   always_comb begin
      perf_cmd_d  = perf_cmd_q + ((cmd_valid_q && cmd_ready) ? 32'd1 : 32'd0);
      perf_busy_d = perf_busy_q + (busy_w ? 32'd1 : 32'd0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_cmd_q  <= '0;
         perf_busy_q <= '0;
      end else begin
         perf_cmd_q  <= perf_cmd_d;
         perf_busy_q <= perf_busy_d;
      end
   end

   assign perf_cmd_cnt  = perf_cmd_q;
   assign perf_busy_cnt = perf_busy_q;
`else
   assign perf_cmd_cnt  = '0;
   assign perf_busy_cnt = '0;
`endif

endmodule

// File: tb/tb_dnn_cmd_decoder.sv
// Self-checking bench for dnn_cmd_decoder: directed scenarios plus a randomized
// run against a transaction-level queue model. Honors DNN_DEC_PERF_EN.
module tb_dnn_cmd_decoder;

   localparam int FIFO_DEPTH = 4;
   localparam int ADDR_W     = 16;
   localparam int LEN_W      = 9;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [31:0]       instruction_to_dnn = '0;
   logic              inst_valid = 1'b0;
   logic              dnn_stall;
   logic              cmd_valid;
   logic              cmd_ready = 1'b0;
   logic [1:0]        cmd_target;
   logic [1:0]        cmd_op;
   logic [ADDR_W-1:0] cmd_addr;
   logic [LEN_W-1:0]  cmd_len;
   logic              dnn_done = 1'b0;
   logic              busy;
   logic              err;
   logic              err_clr = 1'b0;
   logic [31:0]       perf_cmd_cnt;
   logic [31:0]       perf_busy_cnt;

   int errors = 0;
   int checks = 0;

   dnn_cmd_decoder #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .ADDR_W     (ADDR_W),
      .LEN_W      (LEN_W)
   ) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .instruction_to_dnn (instruction_to_dnn),
      .inst_valid         (inst_valid),
      .dnn_stall          (dnn_stall),
      .cmd_valid          (cmd_valid),
      .cmd_ready          (cmd_ready),
      .cmd_target         (cmd_target),
      .cmd_op             (cmd_op),
      .cmd_addr           (cmd_addr),
      .cmd_len            (cmd_len),
      .dnn_done           (dnn_done),
      .busy               (busy),
      .err                (err),
      .err_clr            (err_clr),
      .perf_cmd_cnt       (perf_cmd_cnt),
      .perf_busy_cnt      (perf_busy_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] mk(input logic [1:0] tgt, input logic [4:0] op,
                                      input logic [15:0] addr, input logic [8:0] len);
      return {addr, len, op, tgt};
   endfunction

   // Expected command as the engine should see it: {target, op, addr, len}.
   function automatic logic [28:0] exp_fields(input logic [31:0] w);
      logic [4:0] op5;
      op5 = w[6:2];
      return {w[1:0], op5[1:0], w[31:16], w[15:7]};
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if ({dnn_stall, cmd_valid, cmd_target, cmd_op, cmd_addr, cmd_len, busy, err} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got stall=%0b vld=%0b tgt=%0d op=%0d addr=%h len=%0d busy=%0b err=%0b required all 0",
                  dnn_stall, cmd_valid, cmd_target, cmd_op, cmd_addr, cmd_len, busy, err);
      end
      checks++;
      if (perf_cmd_cnt !== 32'd0 || perf_busy_cnt !== 32'd0) begin
         errors++;
         $display("FAIL reset_perf got cmd=%0d busy=%0d required 0 0", perf_cmd_cnt, perf_busy_cnt);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single_ldw();
      cmd_ready = 1'b1;
      instruction_to_dnn = 32'h1000_0201;
      inst_valid = 1'b1;
      tick();
      inst_valid = 1'b0;
      checks++;
      if (cmd_valid !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL ldw_cycle1 got vld=%0b busy=%0b required vld=0 busy=1", cmd_valid, busy);
      end
      tick();
      checks++;
      if (cmd_valid !== 1'b1 || cmd_target !== 2'd1 || cmd_op !== 2'd0 ||
          cmd_addr !== 16'h1000 || cmd_len !== 9'd4) begin
         errors++;
         $display("FAIL ldw_issue got vld=%0b tgt=%0d op=%0d addr=%h len=%0d required 1 1 0 1000 4",
                  cmd_valid, cmd_target, cmd_op, cmd_addr, cmd_len);
      end
      tick();
      checks++;
      if (cmd_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL ldw_after_hs got vld=%0b busy=%0b required 0 0", cmd_valid, busy);
      end
   endtask

   task automatic test_run_serialization();
      logic [31:0] w_run, w_st;
      int hs_run, hs_st, done_c, early, extra;
      w_run = mk(2'd2, 5'd2, 16'h2000, 9'd16);
      w_st  = mk(2'd2, 5'd3, 16'h3000, 9'd8);
      hs_run = -1; hs_st = -1; done_c = -1; early = 0; extra = 0;
      cmd_ready = 1'b1;
      instruction_to_dnn = w_run;
      inst_valid = 1'b1;
      tick();
      instruction_to_dnn = w_st;
      tick();
      inst_valid = 1'b0;
      for (int c = 0; c < 40; c++) begin
         dnn_done = (hs_run >= 0) && (c == hs_run + 10);
         if (dnn_done) done_c = c;
         if (cmd_valid) begin
            if (hs_run >= 0 && (done_c < 0 || c <= done_c)) early++;
            if (hs_run < 0) begin
               hs_run = c;
               checks++;
               if ({cmd_target, cmd_op, cmd_addr, cmd_len} !== exp_fields(w_run)) begin
                  errors++;
                  $display("FAIL run_fields got %h required %h",
                           {cmd_target, cmd_op, cmd_addr, cmd_len}, exp_fields(w_run));
               end
            end else if (hs_st < 0) begin
               hs_st = c;
               checks++;
               if ({cmd_target, cmd_op, cmd_addr, cmd_len} !== exp_fields(w_st)) begin
                  errors++;
                  $display("FAIL st_fields got %h required %h",
                           {cmd_target, cmd_op, cmd_addr, cmd_len}, exp_fields(w_st));
               end
            end else begin
               extra++;
            end
         end
         tick();
      end
      dnn_done = 1'b0;
      checks++;
      if (hs_run < 0 || hs_st < 0 || early != 0 || extra != 0) begin
         errors++;
         $display("FAIL run_serial got run_hs=%0d st_hs=%0d early=%0d extra=%0d required both seen, 0 early, 0 extra",
                  hs_run, hs_st, early, extra);
      end
      checks++;
      if (hs_st != done_c + 2) begin
         errors++;
         $display("FAIL st_after_done got st cycle %0d required %0d", hs_st, done_c + 2);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] w [6];
      logic [31:0] expq [$];
      int stall_early, unstable, got, timeout;
      stall_early = 0; unstable = 0; got = 0;
      cmd_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         logic [1:0] op2;
         op2 = ($urandom_range(0, 2) == 2) ? 2'd3 : 2'($urandom_range(0, 1));
         w[i] = mk(2'($urandom_range(1, 2)), {3'b000, op2}, 16'($urandom), 9'($urandom));
         expq.push_back(w[i]);
      end
      for (int i = 0; i < 5; i++) begin
         if (dnn_stall !== 1'b0) stall_early++;
         instruction_to_dnn = w[i];
         inst_valid = 1'b1;
         tick();
      end
      inst_valid = 1'b0;
      checks++;
      if (stall_early != 0 || dnn_stall !== 1'b1) begin
         errors++;
         $display("FAIL bp_stall got early_stalls=%0d stall=%0b required 0 and 1", stall_early, dnn_stall);
      end
      instruction_to_dnn = w[5];
      inst_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if (cmd_valid !== 1'b1 || dnn_stall !== 1'b1 ||
             {cmd_target, cmd_op, cmd_addr, cmd_len} !== exp_fields(w[0])) unstable++;
         tick();
      end
      checks++;
      if (unstable != 0) begin
         errors++;
         $display("FAIL bp_hold got %0d unstable cycles required 0", unstable);
      end
      cmd_ready = 1'b1;
      timeout = 1;
      for (int c = 0; c < 60; c++) begin
         logic accept;
         accept = inst_valid && !dnn_stall;
         if (cmd_valid) begin
            checks++;
            if (expq.size() == 0) begin
               errors++;
               $display("FAIL bp_order got unexpected cmd %h required none", {cmd_target, cmd_op, cmd_addr, cmd_len});
            end else begin
               logic [31:0] e;
               e = expq.pop_front();
               got++;
               if ({cmd_target, cmd_op, cmd_addr, cmd_len} !== exp_fields(e)) begin
                  errors++;
                  $display("FAIL bp_order got %h required %h", {cmd_target, cmd_op, cmd_addr, cmd_len}, exp_fields(e));
               end
            end
         end
         tick();
         if (accept) inst_valid = 1'b0;
         if (expq.size() == 0 && !inst_valid && !busy) begin
            timeout = 0;
            break;
         end
      end
      checks++;
      if (timeout != 0 || got != 6) begin
         errors++;
         $display("FAIL bp_drain got %0d commands timeout=%0d required 6 and 0", got, timeout);
      end
   endtask

   task automatic test_filter_illegal();
      int bad;
      bad = 0;
      cmd_ready = 1'b1;
      instruction_to_dnn = 32'hFFFF_FFFF;
      inst_valid = 1'b1;
      tick();
      instruction_to_dnn = 32'h1234_5678 & 32'hFFFF_FFFC;
      tick();
      inst_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (busy !== 1'b0 || cmd_valid !== 1'b0 || dnn_stall !== 1'b0) bad++;
         tick();
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL filter got %0d active cycles required 0", bad);
      end
      instruction_to_dnn = mk(2'd1, 5'd7, 16'hABCD, 9'd3);
      inst_valid = 1'b1;
      tick();
      inst_valid = 1'b0;
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL illegal_early got err=%0b required 0", err);
      end
      bad = 0;
      for (int k = 0; k < 4; k++) begin
         if (cmd_valid !== 1'b0) bad++;
         tick();
      end
      checks++;
      if (err !== 1'b1 || bad != 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL illegal_op got err=%0b issues=%0d busy=%0b required 1 0 0", err, bad, busy);
      end
      instruction_to_dnn = mk(2'd2, 5'd5, 16'h0001, 9'd1);
      inst_valid = 1'b1;
      tick();
      inst_valid = 1'b0;
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      checks++;
      if (err !== 1'b1) begin
         errors++;
         $display("FAIL err_set_wins got err=%0b required 1", err);
      end
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL err_clear got err=%0b required 0", err);
      end
   endtask

   task automatic test_reset_mid_run();
      int seen, bad;
      seen = 0; bad = 0;
      cmd_ready = 1'b1;
      instruction_to_dnn = mk(2'd1, 5'd2, 16'h5555, 9'd100);
      inst_valid = 1'b1;
      tick();
      inst_valid = 1'b0;
      for (int c = 0; c < 10 && seen == 0; c++) begin
         if (cmd_valid) seen = 1;
         tick();
      end
      for (int i = 0; i < 2; i++) begin
         instruction_to_dnn = mk(2'd2, 5'd0, 16'(16'h0100 + i), 9'd2);
         inst_valid = 1'b1;
         tick();
      end
      inst_valid = 1'b0;
      tick();
      checks++;
      if (seen != 1 || busy !== 1'b1 || cmd_valid !== 1'b0) begin
         errors++;
         $display("FAIL pre_reset got run_seen=%0d busy=%0b vld=%0b required 1 1 0", seen, busy, cmd_valid);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({dnn_stall, cmd_valid, cmd_target, cmd_op, cmd_addr, cmd_len, busy, err} !== '0 ||
          perf_cmd_cnt !== 32'd0 || perf_busy_cnt !== 32'd0) begin
         errors++;
         $display("FAIL async_reset got stall=%0b vld=%0b tgt=%0d op=%0d addr=%h len=%0d busy=%0b perf=%0d/%0d required all 0",
                  dnn_stall, cmd_valid, cmd_target, cmd_op, cmd_addr, cmd_len, busy, perf_cmd_cnt, perf_busy_cnt);
      end
      @(negedge clk);
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < 12; k++) begin
         dnn_done = (k == 3);
         if (cmd_valid !== 1'b0 || busy !== 1'b0) bad++;
         tick();
      end
      dnn_done = 1'b0;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL post_reset_idle got %0d active cycles required 0", bad);
      end
   endtask

   task automatic test_perf();
      int busy_seen;
      int exp_cmd, exp_busy;
      busy_seen = 0;
      cmd_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         for (int j = 0; j < 5; j++) begin
            if (j == 0) begin
               instruction_to_dnn = mk(2'($urandom_range(1, 2)), (k == 2) ? 5'd3 : 5'(k),
                                       16'($urandom), 9'($urandom));
               inst_valid = 1'b1;
            end
            if (busy === 1'b1) busy_seen++;
            tick();
            inst_valid = 1'b0;
         end
      end
      checks++;
      if (busy_seen != 6) begin
         errors++;
         $display("FAIL perf_busy_model got %0d busy cycles required 6", busy_seen);
      end
`ifdef DNN_DEC_PERF_EN
      exp_cmd = 3;
      exp_busy = busy_seen;
`else
      exp_cmd = 0;
      exp_busy = 0;
`endif
      checks++;
      if (perf_cmd_cnt !== 32'(exp_cmd) || perf_busy_cnt !== 32'(exp_busy)) begin
         errors++;
         $display("FAIL perf_counters got cmd=%0d busy=%0d required %0d %0d",
                  perf_cmd_cnt, perf_busy_cnt, exp_cmd, exp_busy);
      end
   endtask

   task automatic test_random();
      logic [31:0] expq [$];
      bit drv_done, pending, exp_err;
      int cnt, wait_viol, timeouts, cyc;
      drv_done = 0; pending = 0; exp_err = 0;
      cnt = 0; wait_viol = 0; timeouts = 0; cyc = 0;
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               int kind;
               logic [31:0] w;
               kind = (i == 5) ? 1 : $urandom_range(0, 9);
               if (kind == 0) begin
                  w = mk(($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00, 5'($urandom), 16'($urandom), 9'($urandom));
                  instruction_to_dnn = w;
                  inst_valid = 1'b1;
                  tick();
               end else begin
                  int hold;
                  if (kind == 1) begin
                     w = mk(2'($urandom_range(1, 2)), 5'($urandom_range(4, 31)), 16'($urandom), 9'($urandom));
                     exp_err = 1;
                  end else begin
                     w = mk(2'($urandom_range(1, 2)), 5'($urandom_range(0, 3)), 16'($urandom), 9'($urandom));
                     expq.push_back(w);
                  end
                  instruction_to_dnn = w;
                  inst_valid = 1'b1;
                  hold = 0;
                  while (dnn_stall === 1'b1 && hold < 200) begin
                     tick();
                     hold++;
                  end
                  if (hold >= 200) timeouts++;
                  tick();
               end
               inst_valid = 1'b0;
               repeat ($urandom_range(0, 2)) tick();
            end
            drv_done = 1;
         end
         begin
            while (!(drv_done && expq.size() == 0 && !pending && !busy) && cyc < 4000) begin
               dnn_done = 1'b0;
               if (pending) begin
                  if (cmd_valid) wait_viol++;
                  if (cnt == 0) begin
                     dnn_done = 1'b1;
                     pending = 0;
                  end else begin
                     cnt--;
                  end
               end else if ($urandom_range(0, 7) == 0) begin
                  dnn_done = 1'b1;
               end
               cmd_ready = ($urandom_range(0, 3) != 0);
               if (cmd_valid && cmd_ready) begin
                  checks++;
                  if (expq.size() == 0) begin
                     errors++;
                     $display("FAIL rand_cmd got unexpected %h required none", {cmd_target, cmd_op, cmd_addr, cmd_len});
                  end else begin
                     logic [31:0] e;
                     e = expq.pop_front();
                     if ({cmd_target, cmd_op, cmd_addr, cmd_len} !== exp_fields(e)) begin
                        errors++;
                        $display("FAIL rand_cmd got %h required %h", {cmd_target, cmd_op, cmd_addr, cmd_len}, exp_fields(e));
                     end
                     if (e[6:2] == 5'd2) begin
                        pending = 1;
                        cnt = $urandom_range(0, 6);
                     end
                  end
               end
               tick();
               cyc++;
            end
            dnn_done = 1'b0;
            if (cyc >= 4000) timeouts++;
         end
      join
      checks++;
      if (timeouts != 0 || expq.size() != 0 || wait_viol != 0) begin
         errors++;
         $display("FAIL rand_summary got timeouts=%0d left=%0d wait_issues=%0d required 0 0 0",
                  timeouts, expq.size(), wait_viol);
      end
      checks++;
      if (err !== exp_err || busy !== 1'b0) begin
         errors++;
         $display("FAIL rand_err got err=%0b busy=%0b required %0b 0", err, busy, exp_err);
      end
   endtask

   initial begin
      test_reset();
      test_single_ldw();
      test_run_serialization();
      test_backpressure();
      test_filter_illegal();
      test_reset_mid_run();
      test_perf();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
